// File: rtl/gpu_pkg.sv
// Shared GPU definitions: framebuffer geometry defaults, SRAM word address and
// pixel types, and the row-major pixel address helper.
package gpu_pkg;
  localparam int FB_WIDTH_DEF  = 800;
  localparam int FB_HEIGHT_DEF = 480;
  localparam int X_W = 10;
  localparam int Y_W = 9;

  typedef logic [19:0]    sram_addr_t;
  typedef logic [15:0]    rgb565_t;
  typedef logic [X_W-1:0] coord_x_t;
  typedef logic [Y_W-1:0] coord_y_t;

  // One multiply per command; per-pixel stepping is pure addition.
  function automatic sram_addr_t pix_addr(input sram_addr_t base, input sram_addr_t width,
                                          input coord_x_t x, input coord_y_t y);
    return base + sram_addr_t'(y) * width + sram_addr_t'(x);
  endfunction
endpackage

// File: rtl/sram_fill_if.sv
// Command, status and SRAM bus signals of the rectangle filler.
// A command transfers on a rising edge where cmd_valid and cmd_ready are both 1;
// the offering side holds the cmd fields stable while cmd_valid is high.
interface sram_fill_if;
  import gpu_pkg::*;

  logic       cmd_valid;
  logic       cmd_ready;
  coord_x_t   cmd_x0;
  coord_x_t   cmd_x1;
  coord_y_t   cmd_y0;
  coord_y_t   cmd_y1;
  rgb565_t    cmd_color;
  logic       busy;
  logic       done;
  logic       sram_req;
  logic       sram_gnt;
  sram_addr_t sram_addr;
  rgb565_t    sram_dq_out;
  logic       sram_dq_oe;
  logic       sram_we_n;
  logic       sram_ce_n;
  logic       sram_oe_n;

  modport master (
    input  cmd_valid, cmd_x0, cmd_x1, cmd_y0, cmd_y1, cmd_color, sram_gnt,
    output cmd_ready, busy, done, sram_req, sram_addr, sram_dq_out,
           sram_dq_oe, sram_we_n, sram_ce_n, sram_oe_n
  );

  modport slave (
    output cmd_valid, cmd_x0, cmd_x1, cmd_y0, cmd_y1, cmd_color, sram_gnt,
    input  cmd_ready, busy, done, sram_req, sram_addr, sram_dq_out,
           sram_dq_oe, sram_we_n, sram_ce_n, sram_oe_n
  );
endinterface

// File: rtl/fill_walker.sv
// Row-major walk over a clipped rectangle: x/y position, current SRAM address
// and row start address, all advanced by addition only.
module fill_walker
  import gpu_pkg::*;
#(
  parameter int FB_WIDTH = FB_WIDTH_DEF,
  parameter int FB_BASE  = 0
) (
  input  logic       clk,
  input  logic       sreset,
  input  logic       load,
  input  logic       step,
  input  coord_x_t   x0,
  input  coord_x_t   x1,
  input  coord_y_t   y0,
  input  coord_y_t   y1,
  output sram_addr_t addr,
  output logic       last
);
  localparam sram_addr_t ROW_STEP = sram_addr_t'(FB_WIDTH);
  localparam sram_addr_t BASE     = sram_addr_t'(FB_BASE);

  coord_x_t   x_q, x0_q, x1_q;
  coord_y_t   y_q, y1_q;
  sram_addr_t row_q, addr_q;
  logic       x_more, y_more;

  assign x_more = ({1'b0, x_q} + 11'd1) < {1'b0, x1_q};
  assign y_more = ({1'b0, y_q} + 10'd1) < {1'b0, y1_q};
  assign last   = !x_more && !y_more;
  assign addr   = addr_q;

  always_ff @(posedge clk) begin
    if (sreset) begin
      x_q    <= '0;
      x0_q   <= '0;
      x1_q   <= '0;
      y_q    <= '0;
      y1_q   <= '0;
      row_q  <= '0;
      addr_q <= '0;
    end else if (load) begin
      x_q    <= x0;
      x0_q   <= x0;
      x1_q   <= x1;
      y_q    <= y0;
      y1_q   <= y1;
      row_q  <= pix_addr(BASE, ROW_STEP, x0, y0);
      addr_q <= pix_addr(BASE, ROW_STEP, x0, y0);
    end else if (step) begin
      if (x_more) begin
        x_q    <= x_q + 10'd1;
        addr_q <= addr_q + 20'd1;
      end else if (y_more) begin
        // row_q tracks the address of (x0, y) so a new row needs no multiply
        x_q    <= x0_q;
        y_q    <= y_q + 9'd1;
        row_q  <= row_q + ROW_STEP;
        addr_q <= row_q + ROW_STEP;
      end
    end
  end
endmodule

// File: rtl/sram_fill.sv
// Rectangle fill engine: accepts a clip-and-fill command, arbitrates for the
// SRAM bus and writes one RGB565 word per pixel as a SETUP/PULSE pair.
module sram_fill
  import gpu_pkg::*;
#(
  parameter int FB_WIDTH  = FB_WIDTH_DEF,
  parameter int FB_HEIGHT = FB_HEIGHT_DEF,
  parameter int FB_BASE   = 0
) (
  input  logic         clk,
  input  logic         sreset,
  sram_fill_if.master  bus,
  output logic [2:0]   dbg_state
);
  typedef enum logic [2:0] {IDLE, CLIP, REQ, SETUP, PULSE, DONE} state_e;

  localparam coord_x_t X_LIM = coord_x_t'(FB_WIDTH);
  localparam coord_y_t Y_LIM = coord_y_t'(FB_HEIGHT);

  state_e     state_q, state_d;
  coord_x_t   x0_q, x1_q, x1_clip;
  coord_y_t   y0_q, y1_q, y1_clip;
  rgb565_t    color_q;
  logic       gnt_seen_q;
  logic       accept, empty;
  logic       walk_load, walk_step, walk_last;
  sram_addr_t walk_addr;

  logic       cmd_ready, busy, done, sram_req, sram_dq_oe, sram_we_n, sram_ce_n;
  sram_addr_t sram_addr;
  rgb565_t    sram_dq_out;

  assign accept    = (state_q == IDLE) && bus.cmd_valid;
  assign x1_clip   = (x1_q > X_LIM) ? X_LIM : x1_q;
  assign y1_clip   = (y1_q > Y_LIM) ? Y_LIM : y1_q;
  assign empty     = (x1_clip <= x0_q) || (y1_clip <= y0_q);
  assign walk_load = (state_q == CLIP);
  assign walk_step = (state_q == PULSE);
  assign dbg_state = state_q;

  fill_walker #(
    .FB_WIDTH (FB_WIDTH),
    .FB_BASE  (FB_BASE)
  ) u_walker (
    .clk    (clk),
    .sreset (sreset),
    .load   (walk_load),
    .step   (walk_step),
    .x0     (x0_q),
    .x1     (x1_clip),
    .y0     (y0_q),
    .y1     (y1_clip),
    .addr   (walk_addr),
    .last   (walk_last)
  );

  always_ff @(posedge clk) begin
    if (sreset) begin
      state_q    <= IDLE;
      gnt_seen_q <= 1'b0;
      x0_q       <= '0;
      x1_q       <= '0;
      y0_q       <= '0;
      y1_q       <= '0;
      color_q    <= '0;
    end else begin
      state_q    <= state_d;
      // REQ moves on one cycle after the grant has been sampled
      gnt_seen_q <= (state_q == REQ) && bus.sram_gnt;
      if (accept) begin
        x0_q    <= bus.cmd_x0;
        x1_q    <= bus.cmd_x1;
        y0_q    <= bus.cmd_y0;
        y1_q    <= bus.cmd_y1;
        color_q <= bus.cmd_color;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.cmd_valid) state_d = CLIP;
      CLIP:    state_d = empty ? DONE : REQ;
      REQ:     if (gnt_seen_q) state_d = SETUP;
      SETUP:   if (bus.sram_gnt) state_d = PULSE;
      PULSE:   state_d = walk_last ? DONE : SETUP;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready   = (state_q == IDLE);
    busy        = (state_q != IDLE);
    done        = (state_q == DONE);
    sram_req    = (state_q == REQ) || (state_q == SETUP) || (state_q == PULSE);
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_ce_n   = 1'b1;
    sram_we_n   = 1'b1;
    if (state_q == SETUP) begin
      // Without grant the chip select and data drivers are released
      sram_addr   = walk_addr;
      sram_dq_out = color_q;
      sram_dq_oe  = bus.sram_gnt;
      sram_ce_n   = !bus.sram_gnt;
    end else if (state_q == PULSE) begin
      sram_addr   = walk_addr;
      sram_dq_out = color_q;
      sram_dq_oe  = 1'b1;
      sram_ce_n   = 1'b0;
      sram_we_n   = 1'b0;
    end
  end

  assign bus.cmd_ready   = cmd_ready;
  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.sram_req    = sram_req;
  assign bus.sram_addr   = sram_addr;
  assign bus.sram_dq_out = sram_dq_out;
  assign bus.sram_dq_oe  = sram_dq_oe;
  assign bus.sram_ce_n   = sram_ce_n;
  assign bus.sram_we_n   = sram_we_n;
  assign bus.sram_oe_n   = 1'b1;
endmodule

// File: tb/tb_sram_fill.sv
// Directed bench for sram_fill: write capture, handshake log and latency checks
// against hand-computed addresses and cycle counts.
module tb_sram_fill;
  import gpu_pkg::*;

  logic       clk = 1'b0;
  logic       sreset;
  logic [2:0] dbg_state;
  int         cyc = 0;
  int         n_vec = 0;
  int         n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sram_fill_if bus();

  sram_fill #(
    .FB_WIDTH  (800),
    .FB_HEIGHT (480),
    .FB_BASE   (0)
  ) dut (
    .clk       (clk),
    .sreset    (sreset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // scoreboard state
  logic [19:0] exp_q[$];
  logic [19:0] got_q[$];
  logic [15:0] got_d[$];
  int          acc_q[$];
  int          req_cnt, gap_cnt, gap_bad, oe_bad, done_cnt;

  always @(negedge clk) begin
    if (bus.sram_we_n === 1'b0) begin
      got_q.push_back(bus.sram_addr);
      got_d.push_back(bus.sram_dq_out);
    end
    if (bus.sram_req === 1'b1) req_cnt++;
    if (bus.sram_req === 1'b1 && !bus.sram_gnt && bus.sram_we_n === 1'b1) begin
      gap_cnt++;
      if (bus.sram_ce_n !== 1'b1 || bus.sram_dq_oe !== 1'b0) gap_bad++;
    end
    if (bus.sram_oe_n !== 1'b1) oe_bad++;
    if (bus.done === 1'b1) done_cnt++;
  end

  // inputs are stable here and state has not yet updated for this edge
  always @(posedge clk) begin
    if (bus.cmd_valid && bus.cmd_ready === 1'b1) acc_q.push_back(cyc);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_mon();
    exp_q.delete();
    got_q.delete();
    got_d.delete();
    acc_q.delete();
    req_cnt  = 0;
    gap_cnt  = 0;
    gap_bad  = 0;
    oe_bad   = 0;
    done_cnt = 0;
  endtask

  task automatic check_idle_outputs(input string pfx);
    check({pfx, "_ready"},  32'(bus.cmd_ready),   32'd1);
    check({pfx, "_busy"},   32'(bus.busy),        32'd0);
    check({pfx, "_done"},   32'(bus.done),        32'd0);
    check({pfx, "_req"},    32'(bus.sram_req),    32'd0);
    check({pfx, "_ce_n"},   32'(bus.sram_ce_n),   32'd1);
    check({pfx, "_we_n"},   32'(bus.sram_we_n),   32'd1);
    check({pfx, "_oe_n"},   32'(bus.sram_oe_n),   32'd1);
    check({pfx, "_dq_oe"},  32'(bus.sram_dq_oe),  32'd0);
    check({pfx, "_addr"},   32'(bus.sram_addr),   32'd0);
    check({pfx, "_dq_out"}, 32'(bus.sram_dq_out), 32'd0);
  endtask

  // returns with cyc == hs, where the handshake edge is the next rising edge
  task automatic send_cmd(input logic [9:0] x0, input logic [8:0] y0,
                          input logic [9:0] x1, input logic [8:0] y1,
                          input logic [15:0] color, input bit hold, output int hs);
    int i;
    bus.cmd_x0    = x0;
    bus.cmd_y0    = y0;
    bus.cmd_x1    = x1;
    bus.cmd_y1    = y1;
    bus.cmd_color = color;
    bus.cmd_valid = 1'b1;
    i = 0;
    while (bus.cmd_ready !== 1'b1 && i < 200) begin
      tick();
      i++;
    end
    if (bus.cmd_ready !== 1'b1) check("hs_timeout", 32'd0, 32'd1);
    hs = cyc;
    if (!hold) begin
      tick();
      bus.cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_done(input int hs, input int exp_lat, input string tag);
    int i;
    i = 0;
    do begin
      tick();
      i++;
    end while (bus.done !== 1'b1 && i < 400);
    if (bus.done !== 1'b1) check({tag, "_done_timeout"}, 32'd0, 32'd1);
    else check({tag, "_latency"}, 32'(cyc - hs), 32'(exp_lat));
  endtask

  task automatic compare_writes(input string tag, input logic [15:0] color);
    check({tag, "_nwrites"}, 32'(got_q.size()), 32'(exp_q.size()));
    foreach (exp_q[i]) begin
      if (i < got_q.size()) begin
        check($sformatf("%s_addr%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
        check($sformatf("%s_data%0d", tag, i), 32'(got_d[i]), 32'(color));
      end
    end
  endtask

  initial begin
    int hs;
    int i;
    sreset        = 1'b1;
    bus.sram_gnt  = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_x0    = '0;
    bus.cmd_x1    = '0;
    bus.cmd_y0    = '0;
    bus.cmd_y1    = '0;
    bus.cmd_color = '0;
    repeat (3) tick();
    check_idle_outputs("reset");
    sreset = 1'b0;
    tick();
    check("post_reset_ready", 32'(bus.cmd_ready), 32'd1);

    // 2x2 at the origin, grant tied high
    clear_mon();
    exp_q = '{20'd0, 20'd1, 20'd800, 20'd801};
    send_cmd(10'd0, 9'd0, 10'd2, 9'd2, 16'hF800, 1'b0, hs);
    wait_done(hs, 12, "t1");
    compare_writes("t1", 16'hF800);
    check("t1_req_cycles", 32'(req_cnt), 32'd10);
    check("t1_busy_in_done", 32'(bus.busy), 32'd1);
    tick();
    check("t1_done_count", 32'(done_cnt), 32'd1);

    // bottom-right corner, clipped to 2x2; y1 uses the largest 9-bit value
    clear_mon();
    exp_q = '{20'd383198, 20'd383199, 20'd383998, 20'd383999};
    send_cmd(10'd798, 9'd478, 10'd900, 9'd511, 16'h001F, 1'b0, hs);
    wait_done(hs, 12, "t2");
    compare_writes("t2", 16'h001F);
    tick();

    // zero-width rectangle: no bus activity at all
    clear_mon();
    send_cmd(10'd5, 9'd5, 10'd5, 9'd9, 16'h1234, 1'b0, hs);
    wait_done(hs, 2, "t3");
    check("t3_nwrites", 32'(got_q.size()), 32'd0);
    check("t3_req_cycles", 32'(req_cnt), 32'd0);
    tick();

    // 1x3 column, grant withdrawn for 4 cycles during SETUP of pixel 2
    clear_mon();
    exp_q = '{20'd2410, 20'd3210, 20'd4010};
    send_cmd(10'd10, 9'd3, 10'd11, 9'd6, 16'hABCD, 1'b0, hs);
    repeat (5) tick();
    bus.sram_gnt = 1'b0;
    repeat (4) tick();
    bus.sram_gnt = 1'b1;
    wait_done(hs, 14, "t4");
    compare_writes("t4", 16'hABCD);
    check("t4_gap_cycles", 32'(gap_cnt), 32'd4);
    check("t4_gap_drive", 32'(gap_bad), 32'd0);
    tick();

    // 10x10 fill aborted by reset after 7 pixels
    clear_mon();
    for (int k = 0; k < 7; k++) exp_q.push_back(20'(8000 + k));
    send_cmd(10'd0, 9'd10, 10'd10, 9'd20, 16'h07E0, 1'b0, hs);
    i = 0;
    while (got_q.size() < 7 && i < 300) begin
      tick();
      i++;
    end
    sreset = 1'b1;
    tick();
    check_idle_outputs("abort");
    sreset = 1'b0;
    repeat (20) tick();
    compare_writes("t5", 16'h07E0);
    check("t5_no_done", 32'(done_cnt), 32'd0);

    // command after the abort runs normally
    clear_mon();
    exp_q = '{20'd803, 20'd1603};
    send_cmd(10'd3, 9'd1, 10'd4, 9'd3, 16'h5555, 1'b0, hs);
    wait_done(hs, 8, "t5b");
    compare_writes("t5b", 16'h5555);
    tick();

    // cmd_valid held through a fill: second accept only once back in IDLE
    clear_mon();
    exp_q = '{20'd1, 20'd2, 20'd1, 20'd2};
    send_cmd(10'd1, 9'd0, 10'd3, 9'd1, 16'hFFFF, 1'b1, hs);
    wait_done(hs, 8, "t6a");
    check("t6_accepts_before_done", 32'(acc_q.size()), 32'd1);
    repeat (2) tick();
    bus.cmd_valid = 1'b0;
    wait_done(hs + 9, 8, "t6b");
    check("t6_accepts", 32'(acc_q.size()), 32'd2);
    if (acc_q.size() == 2) check("t6_accept_gap", 32'(acc_q[1] - acc_q[0]), 32'd9);
    compare_writes("t6", 16'hFFFF);
    tick();
    check("t6_done_count", 32'(done_cnt), 32'd2);
    check("oe_n_always_high", 32'(oe_bad), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
